// File: rtl/gt_miss_sequencer_if.sv
// CPU, cache, victim-cache and memory signals of the miss sequencer bundled into one interface.
// The master modport is the sequencer; the slave modport is the surrounding system.
interface gt_miss_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              cpuReq;
  logic [ADDR_W-1:0] cpuAddr;
  logic              cpuReady;
  logic              cpuValid;
  logic [DATA_W-1:0] cpuData;
  logic              cpuErr;

  logic [ADDR_W-1:0] cacheAddr;
  logic              cacheHit;
  logic [DATA_W-1:0] cacheData;
  logic              cacheEvictValid;
  logic [LINE_W-1:0] cacheEvictData;
  logic              cacheFill;
  logic [LINE_W-1:0] fillData;

  logic              victimLookup;
  logic              victimHit;
  logic [LINE_W-1:0] victimData;
  logic              victimWrite;
  logic [LINE_W-1:0] victimWdata;

  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [LINE_W-1:0] memData;

  logic [CNT_W-1:0]  hitCount;
  logic [CNT_W-1:0]  missCount;

  modport master (
    input  cpuReq, cpuAddr,
    output cpuReady, cpuValid, cpuData, cpuErr,
    output cacheAddr, cacheFill, fillData,
    input  cacheHit, cacheData, cacheEvictValid, cacheEvictData,
    output victimLookup, victimWrite, victimWdata,
    input  victimHit, victimData,
    output memReq, memAddr,
    input  memAck, memData,
    output hitCount, missCount
  );

  modport slave (
    output cpuReq, cpuAddr,
    input  cpuReady, cpuValid, cpuData, cpuErr,
    input  cacheAddr, cacheFill, fillData,
    output cacheHit, cacheData, cacheEvictValid, cacheEvictData,
    input  victimLookup, victimWrite, victimWdata,
    output victimHit, victimData,
    input  memReq, memAddr,
    output memAck, memData,
    input  hitCount, missCount
  );
endinterface

// File: rtl/gt_miss_sequencer.sv
// Sequences one CPU byte read through the direct-mapped cache, the victim cache and memory,
// filling the cache line on a miss, swapping the evicted line into the victim cache.
module gt_miss_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  gt_miss_sequencer_if.master bus
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] VICTIM   = 3'd2;
  localparam logic [2:0] MEM_WAIT = 3'd3;
  localparam logic [2:0] FILL     = 3'd4;
  localparam logic [2:0] RESPOND  = 3'd5;

  logic [2:0]        state;
  logic [WAIT_W-1:0] waitCnt;
  logic [ADDR_W-1:0] addrQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [LINE_W-1:0] fillQ;
  logic [DATA_W-1:0] dataQ;
  logic              errQ;
  logic [CNT_W-1:0]  hitCnt;
  logic [CNT_W-1:0]  missCnt;
  logic [OFF_W-1:0]  byteOff;

  assign byteOff = addrQ[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      waitCnt  <= '0;
      addrQ    <= '0;
      memAddrQ <= '0;
      fillQ    <= '0;
      dataQ    <= '0;
      errQ     <= 1'b0;
      hitCnt   <= '0;
      missCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpuReq) begin
            addrQ <= bus.cpuAddr;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus.cacheHit) begin
            dataQ <= bus.cacheData;
            if (hitCnt != '1) hitCnt <= hitCnt + 1'b1;
            state <= RESPOND;
          end else begin
            if (missCnt != '1) missCnt <= missCnt + 1'b1;
            state <= VICTIM;
          end
        end
        VICTIM: begin
          if (bus.victimHit) begin
            fillQ <= bus.victimData;
            state <= FILL;
          end else begin
            memAddrQ <= {addrQ[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            waitCnt  <= '0;
            state    <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // An ack arriving on the final allowed cycle still wins over the timeout.
          if (bus.memAck) begin
            fillQ <= bus.memData;
            state <= FILL;
          end else if (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            errQ  <= 1'b1;
            dataQ <= '0;
            state <= RESPOND;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        FILL: begin
          dataQ <= fillQ[int'(byteOff) * 8 +: DATA_W];
          state <= RESPOND;
        end
        RESPOND: begin
          errQ  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpuReady     = (state == IDLE);
  assign bus.cpuValid     = (state == RESPOND);
  assign bus.cpuData      = dataQ;
  assign bus.cpuErr       = errQ;
  assign bus.cacheAddr    = addrQ;
  assign bus.cacheFill    = (state == FILL);
  assign bus.fillData     = fillQ;
  assign bus.victimLookup = (state == VICTIM);
  // The line being overwritten goes to the victim cache in the same cycle as the fill.
  assign bus.victimWrite  = (state == FILL) && bus.cacheEvictValid;
  assign bus.victimWdata  = bus.victimWrite ? bus.cacheEvictData : '0;
  assign bus.memReq       = (state == MEM_WAIT);
  assign bus.memAddr      = memAddrQ;
  assign bus.hitCount     = hitCnt;
  assign bus.missCount    = missCnt;

endmodule

// File: tb/tb_gt_miss_sequencer.sv
// Directed bench for gt_miss_sequencer: hit, memory miss, victim hit, eviction swap,
// memory timeout, counter saturation and reset during a memory wait.
module tb_gt_miss_sequencer;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 256;
  localparam int DATA_W      = 8;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gt_miss_sequencer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  gt_miss_sequencer #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [LINE_W-1:0] pat;
  logic [LINE_W-1:0] evictPat;

  logic [DATA_W-1:0] rdData;
  logic              rdErr;
  logic              gotValid;
  int                rdLat, fillSeen, vwSeen, vwSame, lookupSeen, memCycles, readyBusy;
  logic [LINE_W-1:0] vwData;
  logic [ADDR_W-1:0] memAddrSeen, addrSeen;

  // One read: request, then watch strobes each cycle until cpuValid or the cycle budget runs out.
  task automatic doRead(input string tag, input logic [31:0] addr, input int ackDelay, input int maxCycles);
    gotValid = 0; rdLat = 0; fillSeen = 0; vwSeen = 0; vwSame = 0; lookupSeen = 0;
    memCycles = 0; readyBusy = 0; vwData = '0; memAddrSeen = '0; addrSeen = '0;
    rdData = '0; rdErr = 1'b0;
    @(negedge clk);
    bus.cpuReq  = 1'b1;
    bus.cpuAddr = addr;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.cpuReq = 1'b0;
        addrSeen   = bus.cacheAddr;
      end
      if (bus.cpuReady) readyBusy++;
      if (bus.cacheFill) fillSeen++;
      if (bus.victimLookup) lookupSeen++;
      if (bus.victimWrite) begin
        vwSeen++;
        vwData = bus.victimWdata;
        if (bus.cacheFill) vwSame++;
      end
      if (bus.memReq) begin
        memCycles++;
        memAddrSeen = bus.memAddr;
        bus.memAck  = (memCycles == ackDelay);
      end else begin
        bus.memAck = 1'b0;
      end
      if (bus.cpuValid) begin
        gotValid = 1'b1;
        rdData   = bus.cpuData;
        rdErr    = bus.cpuErr;
        rdLat    = i;
        break;
      end
    end
    bus.memAck = 1'b0;
    checkVal({tag, "_responded"}, gotValid, 1);
    $display("read %s addr=%08h data=%02h err=%0d lat=%0d fill=%0d vwrite=%0d memcyc=%0d hits=%0d misses=%0d",
             tag, addr, rdData, rdErr, rdLat, fillSeen, vwSeen, memCycles, bus.hitCount, bus.missCount);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) pat[16*k +: 16] = 16'(k * 16'h1111);
    evictPat = {8{32'hC0DE5A5A}};

    bus.cpuReq = 1'b0; bus.cpuAddr = '0;
    bus.cacheHit = 1'b0; bus.cacheData = '0;
    bus.cacheEvictValid = 1'b0; bus.cacheEvictData = evictPat;
    bus.victimHit = 1'b0; bus.victimData = pat;
    bus.memAck = 1'b0; bus.memData = pat;

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("rst_ready", bus.cpuReady, 1);
    checkVal("rst_valid", bus.cpuValid, 0);
    checkVal("rst_err", bus.cpuErr, 0);
    checkVal("rst_strobes", {bus.cacheFill, bus.victimLookup, bus.victimWrite, bus.memReq}, 0);
    checkVal("rst_hits", bus.hitCount, 0);
    checkVal("rst_misses", bus.missCount, 0);
    checkVal("rst_data", bus.cpuData, 0);
    checkVal("rst_addrs", {bus.cacheAddr, bus.memAddr}, 0);
    checkVal("rst_filldata", bus.fillData, 0);
    checkVal("rst_vwdata", bus.victimWdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("post_rst_ready", bus.cpuReady, 1);

    // Cache hit
    bus.cacheHit = 1'b1; bus.cacheData = 8'hA5;
    doRead("hit", 32'h0000_1234, 0, 20);
    checkVal("hit_data", rdData, 8'hA5);
    checkVal("hit_lat", rdLat, 2);
    checkVal("hit_addr", addrSeen, 32'h0000_1234);
    checkVal("hit_busy_ready", readyBusy, 0);
    checkVal("hit_nofill", fillSeen, 0);
    checkVal("hit_count", bus.hitCount, 1);
    checkVal("hit_misscnt", bus.missCount, 0);
    bus.cacheHit = 1'b0;

    // Miss served from memory
    doRead("memmiss", 32'h0020_0002, 5, 40);
    checkVal("mm_memcyc", memCycles, 5);
    checkVal("mm_memaddr", memAddrSeen, 32'h0020_0000);
    checkVal("mm_lookup", lookupSeen, 1);
    checkVal("mm_fill", fillSeen, 1);
    checkVal("mm_novw", vwSeen, 0);
    checkVal("mm_data", rdData, 8'h11);
    checkVal("mm_err", rdErr, 0);
    checkVal("mm_lat", rdLat, 9);
    checkVal("mm_misscnt", bus.missCount, 1);
    checkVal("mm_hitcnt", bus.hitCount, 1);

    // Miss served from the victim cache
    bus.victimHit = 1'b1;
    doRead("vichit", 32'h0010_0004, 0, 20);
    checkVal("vh_nomem", memCycles, 0);
    checkVal("vh_fill", fillSeen, 1);
    checkVal("vh_data", rdData, 8'h22);
    checkVal("vh_lat", rdLat, 4);
    checkVal("vh_misscnt", bus.missCount, 2);

    // Eviction swap into the victim cache
    bus.cacheEvictValid = 1'b1;
    doRead("evict", 32'h0230_00F3, 0, 20);
    checkVal("ev_vwrite", vwSeen, 1);
    checkVal("ev_samecycle", vwSame, 1);
    checkVal("ev_vwdata", vwData, evictPat);
    checkVal("ev_data", rdData, 8'h99);
    checkVal("ev_misscnt", bus.missCount, 3);
    bus.cacheEvictValid = 1'b0;
    bus.victimHit = 1'b0;

    // Memory timeout
    doRead("timeout", 32'h0040_0010, 0, 100);
    checkVal("to_err", rdErr, 1);
    checkVal("to_data", rdData, 0);
    checkVal("to_nofill", fillSeen, 0);
    checkVal("to_memcyc", memCycles, MEM_TIMEOUT);
    checkVal("to_misscnt", bus.missCount, 4);
    @(negedge clk);
    checkVal("to_ready", bus.cpuReady, 1);
    checkVal("to_errclr", bus.cpuErr, 0);

    // Drive misses until the narrow miss counter reaches all-ones, then one more
    bus.victimHit = 1'b1;
    for (int k = 0; k < 11; k++) doRead("satfill", 32'h0050_0000 + 32'(k), 0, 20);
    checkVal("sat_full", bus.missCount, 4'hF);
    doRead("satover", 32'h0050_0100, 0, 20);
    checkVal("sat_hold", bus.missCount, 4'hF);
    checkVal("sat_hitcnt", bus.hitCount, 1);
    bus.victimHit = 1'b0;

    // Reset while waiting on memory
    @(negedge clk);
    bus.cpuReq = 1'b1; bus.cpuAddr = 32'h0060_0000;
    @(negedge clk);
    bus.cpuReq = 1'b0;
    for (int i = 0; i < 10 && !bus.memReq; i++) @(negedge clk);
    checkVal("mr_memreq_up", bus.memReq, 1);
    rst_n = 1'b0;
    #1;
    checkVal("mr_memreq_drop", bus.memReq, 0);
    checkVal("mr_ready", bus.cpuReady, 1);
    checkVal("mr_counts", {bus.hitCount, bus.missCount}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int spurious = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.cpuValid || bus.cacheFill || bus.victimWrite || bus.memReq) spurious++;
      end
      checkVal("mr_quiet", spurious, 0);
    end
    $display("reset_mid_wait hits=%0d misses=%0d ready=%0d", bus.hitCount, bus.missCount, bus.cpuReady);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
